// File: rtl/forward_unit_pkg.sv
// Shared types and layout constants for the decode-stage forwarding producer.
package forward_unit_pkg;

  localparam int unsigned REG_W     = 3;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned NUM_SLOTS = 3;
  localparam int unsigned FIELD_W   = REG_W + 1;
  localparam int unsigned FV_W      = NUM_SLOTS * FIELD_W;
  localparam int unsigned FD_W      = NUM_SLOTS * DATA_W;

  // Bit offsets of each slot field inside Forwarding_vector
  localparam int unsigned EX_OFF    = 0;
  localparam int unsigned MEM_OFF   = 4;
  localparam int unsigned WB_OFF    = 8;
  localparam int unsigned VALID_OFF = 3;

  // Bit offsets of each data lane inside Forwarding_data
  localparam int unsigned EX_LANE  = 0;
  localparam int unsigned MEM_LANE = 16;
  localparam int unsigned WB_LANE  = 32;

  // One in-flight register write
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] tag;
    logic             ld;
  } slot_t;

  localparam slot_t SLOT_RESET = '{v: 1'b0, tag: '0, ld: 1'b0};

  // Build one {valid, tag} field; the tag is always reported, valid is gated by the caller
  function automatic logic [FIELD_W-1:0] fwd_field(input slot_t s, input logic fwd_ok);
    logic [FIELD_W-1:0] f;
    f                = '0;
    f[REG_W-1:0]     = s.tag;
    f[VALID_OFF]     = fwd_ok;
    return f;
  endfunction

  // Source operand matches the slot destination
  function automatic logic tag_hit(input logic used, input logic [REG_W-1:0] sel,
                                   input slot_t s);
    return used & (sel == s.tag);
  endfunction

endpackage

// File: rtl/forward_unit_slot.sv
// Single registered pipeline slot with synchronous reset, load enable and bubble injection.
module fwd_slot
  import forward_unit_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  logic  bubble,
  input  slot_t d,
  output slot_t q
);

  // Register the slot; a bubble kills v and ld but keeps the tag visible
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SLOT_RESET;
    end else if (en) begin
      q.v   <= d.v & ~bubble;
      q.tag <= d.tag;
      q.ld  <= d.ld & ~bubble;
    end
  end

endmodule

// File: rtl/forward_unit.sv
// Forwarding producer: tracks destination tags through EX/MEM/WB, flags load-use hazards.
module forward_unit
  import forward_unit_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Dec_Valid,
  input  logic              Dec_RegWrite,
  input  logic              Dec_MemRead,
  input  logic [REG_W-1:0]  Dec_Write_reg_sel,
  input  logic [REG_W-1:0]  Read1_sel,
  input  logic [REG_W-1:0]  Read2_sel,
  input  logic              Read1_used,
  input  logic              Read2_used,
  input  logic              Flush,
  input  logic [DATA_W-1:0] Ex_result,
  input  logic [DATA_W-1:0] Mem_result,
  input  logic [DATA_W-1:0] Wb_data,
  output logic [FV_W-1:0]   Forwarding_vector,
  output logic [FD_W-1:0]   Forwarding_data,
  output logic              Stall,
  output logic [CNT_W-1:0]  Stall_count,
  output logic              err
);

  slot_t ex_new;
  slot_t ex_q;
  slot_t mem_q;
  slot_t wb_q;
  logic  ex_bubble;
  logic  src_hit;

  // Candidate EX entry from the decode instruction
  always_comb begin
    ex_new     = SLOT_RESET;
    ex_new.v   = Dec_Valid & Dec_RegWrite;
    ex_new.tag = Dec_Write_reg_sel;
    ex_new.ld  = Dec_Valid & Dec_RegWrite & Dec_MemRead;
  end

  // Load-use hazard against the EX slot; flush suppresses it
  always_comb begin
    src_hit = tag_hit(Read1_used, Read1_sel, ex_q) | tag_hit(Read2_used, Read2_sel, ex_q);
    Stall   = Dec_Valid & ~Flush & ex_q.v & ex_q.ld & src_hit;
  end

  // Killed or held decode instructions enter EX as bubbles
  always_comb begin
    ex_bubble = Flush | Stall;
  end

  fwd_slot u_ex (
    .clk    (clk),
    .rst    (rst),
    .en     (1'b1),
    .bubble (ex_bubble),
    .d      (ex_new),
    .q      (ex_q)
  );

  fwd_slot u_mem (
    .clk    (clk),
    .rst    (rst),
    .en     (1'b1),
    .bubble (1'b0),
    .d      (ex_q),
    .q      (mem_q)
  );

  fwd_slot u_wb (
    .clk    (clk),
    .rst    (rst),
    .en     (1'b1),
    .bubble (1'b0),
    .d      (mem_q),
    .q      (wb_q)
  );

  // Publish slot tags; EX loads are not forwardable yet
  always_comb begin
    Forwarding_vector                     = '0;
    Forwarding_vector[EX_OFF  +: FIELD_W] = fwd_field(ex_q, ex_q.v & ~ex_q.ld);
    Forwarding_vector[MEM_OFF +: FIELD_W] = fwd_field(mem_q, mem_q.v);
    Forwarding_vector[WB_OFF  +: FIELD_W] = fwd_field(wb_q, wb_q.v);
  end

  // Data lanes are a straight concatenation of the stage results
  always_comb begin
    Forwarding_data                     = '0;
    Forwarding_data[EX_LANE  +: DATA_W] = Ex_result;
    Forwarding_data[MEM_LANE +: DATA_W] = Mem_result;
    Forwarding_data[WB_LANE  +: DATA_W] = Wb_data;
  end

  // A load without a register write is malformed decode control
  always_comb begin
    err = Dec_Valid & Dec_MemRead & ~Dec_RegWrite;
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      Stall_count <= '0;
    end else if (Stall && (Stall_count != {CNT_W{1'b1}})) begin
      Stall_count <= Stall_count + CNT_W'(1);
    end
  end

endmodule
